irf_window_seq: RTL and testbench
=================================

IRF_WINDOW_SEQ -- requirements
Module: irf_window_seq

Interface
REQ-001 The block SHALL have parameter NTHR, default 4: number of hardware threads; this specification covers only the value 4.
REQ-002 The block SHALL have parameter WIN_W, default 3: window-pointer width, giving 8 windows per thread.
REQ-003 The block SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst_l  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req_vld  in  4  per-thread request valid, held until the matching req_ack.
REQ-006 The block SHALL have port req_op  in  8  2 bits per thread: 00 NOP, 01 SAVE, 10 RESTORE, 11 SWAP.
REQ-007 The block SHALL have port req_cwp  in  12  3 bits per thread: window to save.
REQ-008 The block SHALL have port req_nwp  in  12  3 bits per thread: window to restore.
REQ-009 The block SHALL have port req_ack  out  4  one-cycle completion pulse per thread.
REQ-010 The block SHALL have port irf_save  out  1  save strobe broadcast to all register cells.
REQ-011 The block SHALL have port irf_save_addr  out  5  {thread[1:0], window[2:0]} for the save.
REQ-012 The block SHALL have port irf_restore  out  1  restore strobe broadcast to all register cells.
REQ-013 The block SHALL have port irf_restore_addr  out  5  {thread[1:0], window[2:0]} for the restore.
REQ-014 The block SHALL have port thr_stall  out  4  blocks architectural register writes of the owning thread.
REQ-015 The block SHALL have port busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, SAVE, GAP, RESTORE and ACK; every output SHALL be registered.
REQ-017 In IDLE with any req_vld set, the block SHALL grant one thread round-robin: the lowest index at or after rr_ptr, with wrap-around.
REQ-018 On each grant, rr_ptr SHALL be set to granted index + 1 (mod 4).
REQ-019 At grant, the block SHALL latch owner, op, cwp and nwp; later changes on req_* SHALL be ignored until ACK.
REQ-020 Transitions from the grant in IDLE SHALL be: SWAP -> SAVE -> GAP -> RESTORE -> ACK; SAVE -> SAVE -> GAP -> ACK; RESTORE -> RESTORE -> ACK; NOP -> ACK.
REQ-021 A SWAP with cwp == nwp SHALL go directly to ACK with no save or restore strobe.
REQ-022 GAP SHALL last exactly 1 cycle, covering the cell's one-cycle-delayed negedge save write before any restore or new grant.
REQ-023 irf_save SHALL be 1 only in SAVE, with irf_save_addr = {owner, cwp}; otherwise irf_save = 0 and irf_save_addr = 0.
REQ-024 irf_restore SHALL be 1 only in RESTORE, with irf_restore_addr = {owner, nwp}; otherwise irf_restore = 0 and irf_restore_addr = 0.
REQ-025 irf_save and irf_restore SHALL never be asserted in the same cycle.
REQ-026 req_ack[owner] SHALL be 1 for exactly the ACK cycle; ACK SHALL always return to IDLE.
REQ-027 Requests SHALL be sampled only in IDLE, so a thread still holding req_vld in the ACK cycle cannot be re-granted before the following cycle.
REQ-028 thr_stall[owner] SHALL be 1 in every non-IDLE state; all other thr_stall bits SHALL be 0.
REQ-029 SWAP latency SHALL be: grant at cycle t, save at t+1, GAP at t+2, restore at t+3, ack at t+4.
REQ-030 SAVE-only and RESTORE-only latency SHALL be: ack at t+3 and t+2 respectively.

Reset
REQ-031 Asserting rst_l low SHALL asynchronously force: state IDLE, rr_ptr 0, latched fields 0, and every output 0 (including req_ack, strobes, addresses, thr_stall and busy).
REQ-032 Reset during an operation SHALL abandon it: no ack and no further strobes are issued, and the requester re-requests after reset.
REQ-033 Release of rst_l SHALL take effect at the next posedge clk.

Structure
REQ-034 Shared package irf_ctl_pkg SHALL hold the FSM state enum, the op encodings (NOP/SAVE/RESTORE/SWAP) and the NTHR/WIN_W default constants.
REQ-035 The round-robin selection SHALL be one sub-module, irf_rr_arb4: 4-bit request plus 2-bit pointer in, one-hot grant and index out, purely combinational.
REQ-036 The FSM, latches and output registers SHALL reside in irf_window_seq.

Verification
REQ-037 Reset behaviour: rst_l low mid-SWAP in RESTORE -> all outputs 0 immediately; after release, no ack for the abandoned request.
REQ-038 Single SWAP: thread 2, cwp=5, nwp=6 -> save_addr=0x15 at t+1, restore_addr=0x16 at t+3, ack[2] at t+4, thr_stall=0100 over t+1..t+4.
REQ-039 Round-robin: all 4 threads request SAVE continuously from reset -> grant order 0,1,2,3,0, with 4 idle-to-ack gaps, no thread starved.
REQ-040 Degenerate SWAP: thread 1, cwp=nwp=3 -> no strobes, ack[1] at t+1.
REQ-041 Wrap: rr_ptr=3, requests from threads 0 and 3 -> thread 3 granted first, then thread 0; the bench asserts that save and restore are never high together.
REQ-042 NOP and RESTORE-only: thread 0 NOP -> ack at t+1; thread 3 RESTORE, nwp=7 -> restore_addr=0x1F at t+1, ack at t+2.

Source files
------------

// File: rtl/irf_ctl_pkg.sv
// Shared types for the integer register file window sequencer: FSM states,
// window-op encodings and default sizing.
package irf_ctl_pkg;
  localparam int NTHR_DEF  = 4;
  localparam int WIN_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_GAP     = 3'd2,
    ST_RESTORE = 3'd3,
    ST_ACK     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_SAVE    = 2'b01,
    OP_RESTORE = 2'b10,
    OP_SWAP    = 2'b11
  } op_e;
endpackage

// File: rtl/irf_rr_arb4.sv
// Four-way round-robin picker: first requester at or after i_ptr, wrapping.
// Purely combinational.
module irf_rr_arb4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_gnt,
  output logic [1:0] o_idx
);
  logic [1:0] w_j;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_j   = '0;
    for (int k = 3; k >= 0; k--) begin
      w_j = i_ptr + 2'(k);
      if (i_req[w_j]) begin
        o_gnt = 4'b0001 << w_j;
        o_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/irf_window_seq.sv
// Register-window save/restore sequencer: grants one thread at a time and
// walks SAVE -> GAP -> RESTORE -> ACK with registered strobes and addresses.
module irf_window_seq
  import irf_ctl_pkg::*;
#(
  parameter  int NTHR  = NTHR_DEF,
  parameter  int WIN_W = WIN_W_DEF,
  localparam int TW    = $clog2(NTHR)
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic [NTHR-1:0]         req_vld,
  input  logic [2*NTHR-1:0]       req_op,
  input  logic [WIN_W*NTHR-1:0]   req_cwp,
  input  logic [WIN_W*NTHR-1:0]   req_nwp,
  output logic [NTHR-1:0]         req_ack,
  output logic                    irf_save,
  output logic [TW+WIN_W-1:0]     irf_save_addr,
  output logic                    irf_restore,
  output logic [TW+WIN_W-1:0]     irf_restore_addr,
  output logic [NTHR-1:0]         thr_stall,
  output logic                    busy
);
  state_e             r_st, w_nxt;
  op_e                r_op, w_op_req;
  logic [TW-1:0]      r_own, r_rr, w_idx, w_own_n;
  logic [WIN_W-1:0]   r_cwp, r_nwp, w_cwp_req, w_nwp_req, w_cwp_n, w_nwp_n;
  logic [NTHR-1:0]    w_gnt;
  logic               w_take;

  logic [NTHR-1:0]    r_ack, w_ack, r_stall, w_stall;
  logic               r_save, w_save, r_rest, w_rest, r_busy, w_busy;
  logic [TW+WIN_W-1:0] r_sa, w_sa, r_ra, w_ra;

  irf_rr_arb4 u_arb (
    .i_req (req_vld),
    .i_ptr (r_rr),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_take    = (r_st == ST_IDLE) && (|w_gnt);
  assign w_op_req  = op_e'(req_op[w_idx*2 +: 2]);
  assign w_cwp_req = req_cwp[w_idx*WIN_W +: WIN_W];
  assign w_nwp_req = req_nwp[w_idx*WIN_W +: WIN_W];

  // Fields as they will be held next cycle; outputs decode from these.
  assign w_own_n = w_take ? w_idx     : r_own;
  assign w_cwp_n = w_take ? w_cwp_req : r_cwp;
  assign w_nwp_n = w_take ? w_nwp_req : r_nwp;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_own <= '0;
      r_op  <= OP_NOP;
      r_cwp <= '0;
      r_nwp <= '0;
      r_rr  <= '0;
    end else if (w_take) begin
      r_own <= w_idx;
      r_op  <= w_op_req;
      r_cwp <= w_cwp_req;
      r_nwp <= w_nwp_req;
      r_rr  <= w_idx + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_st    <= ST_IDLE;
      r_ack   <= '0;
      r_save  <= 1'b0;
      r_sa    <= '0;
      r_rest  <= 1'b0;
      r_ra    <= '0;
      r_stall <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_st    <= w_nxt;
      r_ack   <= w_ack;
      r_save  <= w_save;
      r_sa    <= w_sa;
      r_rest  <= w_rest;
      r_ra    <= w_ra;
      r_stall <= w_stall;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_nxt = r_st;
    case (r_st)
      ST_IDLE: begin
        if (w_take) begin
          case (w_op_req)
            OP_SWAP:    w_nxt = (w_cwp_req == w_nwp_req) ? ST_ACK : ST_SAVE;
            OP_SAVE:    w_nxt = ST_SAVE;
            OP_RESTORE: w_nxt = ST_RESTORE;
            default:    w_nxt = ST_ACK;
          endcase
        end
      end
      ST_SAVE:    w_nxt = ST_GAP;
      // GAP lets the cell finish its delayed save write before anything else.
      ST_GAP:     w_nxt = (r_op == OP_SWAP) ? ST_RESTORE : ST_ACK;
      ST_RESTORE: w_nxt = ST_ACK;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_save  = (w_nxt == ST_SAVE);
    w_rest  = (w_nxt == ST_RESTORE);
    w_sa    = w_save ? {w_own_n, w_cwp_n} : '0;
    w_ra    = w_rest ? {w_own_n, w_nwp_n} : '0;
    w_busy  = (w_nxt != ST_IDLE);
    w_stall = w_busy ? (NTHR'(1) << w_own_n) : '0;
    w_ack   = (w_nxt == ST_ACK) ? (NTHR'(1) << w_own_n) : '0;
  end

  assign req_ack          = r_ack;
  assign irf_save         = r_save;
  assign irf_save_addr    = r_sa;
  assign irf_restore      = r_rest;
  assign irf_restore_addr = r_ra;
  assign thr_stall        = r_stall;
  assign busy             = r_busy;
endmodule

// File: tb/tb_irf_window_seq.sv
// Bench for irf_window_seq: directed scenarios plus randomized traffic
// against a transaction-level model that emits expected output frames.
module tb_irf_window_seq;
  typedef struct packed {
    logic [3:0] ack;
    logic       sv;
    logic [4:0] sa;
    logic       rs;
    logic [4:0] ra;
    logic [3:0] st;
    logic       bz;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [3:0]  req_vld = '0;
  logic [7:0]  req_op = '0;
  logic [11:0] req_cwp = '0;
  logic [11:0] req_nwp = '0;
  logic [3:0]  req_ack;
  logic        irf_save;
  logic [4:0]  irf_save_addr;
  logic        irf_restore;
  logic [4:0]  irf_restore_addr;
  logic [3:0]  thr_stall;
  logic        busy;
  frame_t      act;

  int checks = 0;
  int errors = 0;

  irf_window_seq dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .req_vld          (req_vld),
    .req_op           (req_op),
    .req_cwp          (req_cwp),
    .req_nwp          (req_nwp),
    .req_ack          (req_ack),
    .irf_save         (irf_save),
    .irf_save_addr    (irf_save_addr),
    .irf_restore      (irf_restore),
    .irf_restore_addr (irf_restore_addr),
    .thr_stall        (thr_stall),
    .busy             (busy)
  );

  assign act = {req_ack, irf_save, irf_save_addr, irf_restore, irf_restore_addr, thr_stall, busy};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic frame_t fr(input logic [3:0] ack, input logic sv, input logic [4:0] sa,
                                input logic rs, input logic [4:0] ra, input logic [3:0] st);
    fr = {ack, sv, sa, rs, ra, st, |st};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int t, input logic [1:0] op, input logic [2:0] c, input logic [2:0] n);
    req_vld[t]        = 1'b1;
    req_op[t*2 +: 2]  = op;
    req_cwp[t*3 +: 3] = c;
    req_nwp[t*3 +: 3] = n;
  endtask

  task automatic clr_req();
    req_vld = '0; req_op = '0; req_cwp = '0; req_nwp = '0;
  endtask

  task automatic do_reset();
    clr_req();
    rst_l = 1'b0;
    cyc();
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    clr_req();
    rst_l = 1'b0;
    #2;
    checks++;
    if (act !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", act); end
    req_vld = 4'b1111; req_op = 8'hFF; req_cwp = 12'h123;
    cyc();
    checks++;
    if (act !== '0) begin errors++; $display("FAIL reset_held got %h exp 0", act); end
    clr_req();
    rst_l = 1'b1;
    cyc();
    checks++;
    if (act !== '0) begin errors++; $display("FAIL reset_release got %h exp 0", act); end
  endtask

  task automatic test_round_robin();
    frame_t e;
    int g;
    do_reset();
    for (int t = 0; t < 4; t++) set_req(t, 2'b01, 3'(t + 2), 3'd0);
    for (int i = 0; i < 20; i++) begin
      g = (i / 4) % 4;
      case (i % 4)
        0: e = fr(4'd0, 1'b1, {2'(g), 3'(g + 2)}, 1'b0, 5'd0, 4'b0001 << g);
        1: e = fr(4'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0001 << g);
        2: e = fr(4'b0001 << g, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0001 << g);
        default: e = '0;
      endcase
      cyc();
      checks++;
      if (act !== e) begin errors++; $display("FAIL rr_c%0d got %h exp %h", i, act, e); end
    end
    clr_req();
  endtask

  task automatic test_wrap();
    frame_t e [0:9];
    do_reset();
    // A NOP from thread 2 leaves the pointer at 3.
    set_req(2, 2'b00, 3'd0, 3'd0);
    cyc();
    checks++;
    if (act !== fr(4'b0100, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0100)) begin
      errors++; $display("FAIL wrap_nop got %h", act);
    end
    clr_req();
    cyc();
    set_req(0, 2'b11, 3'd4, 3'd0);
    set_req(3, 2'b11, 3'd1, 3'd2);
    e[0] = fr(4'd0, 1'b1, 5'h19, 1'b0, 5'd0, 4'b1000);
    e[1] = fr(4'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'b1000);
    e[2] = fr(4'd0, 1'b0, 5'd0, 1'b1, 5'h1A, 4'b1000);
    e[3] = fr(4'b1000, 1'b0, 5'd0, 1'b0, 5'd0, 4'b1000);
    e[4] = '0;
    e[5] = fr(4'd0, 1'b1, 5'h04, 1'b0, 5'd0, 4'b0001);
    e[6] = fr(4'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0001);
    e[7] = fr(4'd0, 1'b0, 5'd0, 1'b1, 5'h00, 4'b0001);
    e[8] = fr(4'b0001, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0001);
    e[9] = '0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (act !== e[i]) begin errors++; $display("FAIL wrap_c%0d got %h exp %h", i, act, e[i]); end
      checks++;
      if (irf_save && irf_restore) begin errors++; $display("FAIL wrap_excl_c%0d both strobes high", i); end
      if (i == 3) req_vld[3] = 1'b0;
      if (i == 8) req_vld[0] = 1'b0;
    end
    clr_req();
  endtask

  task automatic test_single_swap();
    frame_t e [0:4];
    set_req(2, 2'b11, 3'd5, 3'd6);
    e[0] = fr(4'd0, 1'b1, 5'h15, 1'b0, 5'd0, 4'b0100);
    e[1] = fr(4'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0100);
    e[2] = fr(4'd0, 1'b0, 5'd0, 1'b1, 5'h16, 4'b0100);
    e[3] = fr(4'b0100, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0100);
    e[4] = '0;
    // Request stays up through ACK: no regrant may appear in the next cycle.
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (act !== e[i]) begin errors++; $display("FAIL swap_t%0d got %h exp %h", i + 1, act, e[i]); end
    end
    clr_req();
  endtask

  task automatic test_degenerate_swap();
    set_req(1, 2'b11, 3'd3, 3'd3);
    cyc();
    checks++;
    if (act !== fr(4'b0010, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0010)) begin
      errors++; $display("FAIL degen_ack got %h", act);
    end
    clr_req();
    cyc();
    checks++;
    if (act !== '0) begin errors++; $display("FAIL degen_idle got %h exp 0", act); end
  endtask

  task automatic test_nop_restore();
    frame_t e [0:2];
    set_req(0, 2'b00, 3'd2, 3'd5);
    cyc();
    checks++;
    if (act !== fr(4'b0001, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0001)) begin
      errors++; $display("FAIL nop_ack got %h", act);
    end
    clr_req();
    cyc();
    checks++;
    if (act !== '0) begin errors++; $display("FAIL nop_idle got %h exp 0", act); end
    set_req(3, 2'b10, 3'd1, 3'd7);
    e[0] = fr(4'd0, 1'b0, 5'd0, 1'b1, 5'h1F, 4'b1000);
    e[1] = fr(4'b1000, 1'b0, 5'd0, 1'b0, 5'd0, 4'b1000);
    e[2] = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (act !== e[i]) begin errors++; $display("FAIL rest_t%0d got %h exp %h", i + 1, act, e[i]); end
      if (i == 1) clr_req();
    end
  endtask

  task automatic test_reset_mid();
    set_req(2, 2'b11, 3'd5, 3'd6);
    cyc(); cyc(); cyc();
    checks++;
    if (act !== fr(4'd0, 1'b0, 5'd0, 1'b1, 5'h16, 4'b0100)) begin
      errors++; $display("FAIL rstmid_restore got %h", act);
    end
    rst_l = 1'b0;
    #1;
    checks++;
    if (act !== '0) begin errors++; $display("FAIL rstmid_async got %h exp 0", act); end
    clr_req();
    cyc();
    rst_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (act !== '0) begin errors++; $display("FAIL rstmid_noack_c%0d got %h exp 0", i, act); end
    end
    set_req(2, 2'b11, 3'd5, 3'd6);
    cyc(); cyc(); cyc(); cyc();
    checks++;
    if (act !== fr(4'b0100, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0100)) begin
      errors++; $display("FAIL rstmid_rereq got %h", act);
    end
    clr_req();
    cyc();
  endtask

  task automatic test_random();
    frame_t q[$];
    frame_t e, fs, fg, frr, fa;
    int rr, own, j;
    bit pend [4];
    logic [1:0] pop [4];
    logic [2:0] pc [4];
    logic [2:0] pn [4];
    logic [1:0] jj;
    logic [3:0] oh;
    do_reset();
    rr = 0; own = -1;
    for (int t = 0; t < 4; t++) begin pend[t] = 0; pop[t] = '0; pc[t] = '0; pn[t] = '0; end
    for (int cnum = 0; cnum < 400; cnum++) begin
      for (int t = 0; t < 4; t++) begin
        if (!pend[t] && $urandom_range(0, 2) == 0) begin
          pend[t] = 1;
          pop[t]  = 2'($urandom);
          pc[t]   = 3'($urandom);
          pn[t]   = ($urandom_range(0, 3) == 0) ? pc[t] : 3'($urandom);
        end
      end
      // Owner's fields are latched at grant; wiggling them must have no effect.
      if (own >= 0 && $urandom_range(0, 1) == 1) begin
        pop[own] = 2'($urandom); pc[own] = 3'($urandom); pn[own] = 3'($urandom);
      end
      for (int t = 0; t < 4; t++) begin
        req_vld[t] = pend[t];
        req_op[t*2 +: 2] = pop[t];
        req_cwp[t*3 +: 3] = pc[t];
        req_nwp[t*3 +: 3] = pn[t];
      end
      if (q.size() == 0) begin
        j = -1;
        for (int k = 0; k < 4; k++)
          if (j < 0 && pend[(rr + k) % 4]) j = (rr + k) % 4;
        if (j >= 0) begin
          own = j; jj = 2'(j); oh = 4'b0001 << j;
          fs  = fr(4'd0, 1'b1, {jj, pc[j]}, 1'b0, 5'd0, oh);
          fg  = fr(4'd0, 1'b0, 5'd0, 1'b0, 5'd0, oh);
          frr = fr(4'd0, 1'b0, 5'd0, 1'b1, {jj, pn[j]}, oh);
          fa  = fr(oh, 1'b0, 5'd0, 1'b0, 5'd0, oh);
          case (pop[j])
            2'b11: if (pc[j] == pn[j]) q.push_back(fa);
                   else begin q.push_back(fs); q.push_back(fg); q.push_back(frr); q.push_back(fa); end
            2'b01: begin q.push_back(fs); q.push_back(fg); q.push_back(fa); end
            2'b10: begin q.push_back(frr); q.push_back(fa); end
            default: q.push_back(fa);
          endcase
          q.push_back('0);
          rr = (j + 1) % 4;
        end
      end
      e = (q.size() > 0) ? q.pop_front() : '0;
      cyc();
      checks++;
      if (act !== e) begin errors++; $display("FAIL rand_c%0d got %h exp %h", cnum, act, e); end
      checks++;
      if (irf_save && irf_restore) begin errors++; $display("FAIL rand_excl_c%0d both strobes high", cnum); end
      if (e.ack != 4'd0) begin
        for (int t = 0; t < 4; t++) if (e.ack[t]) pend[t] = 0;
        own = -1;
      end
    end
    clr_req();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_single_swap();
    test_degenerate_swap();
    test_nop_restore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
